// File: rtl/sii_ncu_pkt_mon_if.sv
// SII->NCU inbound bus as seen by the passive packet monitor.
// The master side drives the wires, the monitor observes them.
interface sii_ncu_pkt_mon_if #(
    parameter int DATA_W = 32,
    parameter int PAR_W  = 2
);
    logic              sii_ncu_req;
    logic [DATA_W-1:0] sii_ncu_data;
    logic [PAR_W-1:0]  sii_ncu_dparity;
    logic              ncu_sii_gnt;

    modport master (
        output sii_ncu_req,
        output sii_ncu_data,
        output sii_ncu_dparity,
        output ncu_sii_gnt
    );

    modport slave (
        input sii_ncu_req,
        input sii_ncu_data,
        input sii_ncu_dparity,
        input ncu_sii_gnt
    );
endinterface

// File: rtl/sii_ncu_pkt_mon.sv
// Passive SII->NCU packet monitor: reassembly, parity, credit checks.
// Optional grant timeout: define SIU_NCU_MON_TIMEOUT_EN.
module sii_ncu_pkt_mon #(
    parameter int DATA_W  = 32,
    parameter int PAR_W   = 2,
    parameter int BEATS   = 4,
    parameter int CREDITS = 2,
    parameter int CNT_W   = 16
`ifdef SIU_NCU_MON_TIMEOUT_EN
    ,
    parameter int GNT_TIMEOUT = 256
`endif
) (
    input  logic                         iol2clk,
    input  logic                         rst_l,
    input  logic                         enable,
    sii_ncu_pkt_mon_if.slave             bus,
    output logic                         pkt_valid,
    output logic [DATA_W*BEATS-1:0]      pkt_data,
    output logic                         pkt_par_err,
    output logic [$clog2(CREDITS+1)-1:0] credits,
    output logic [CNT_W-1:0]             pkt_cnt,
    output logic [CNT_W-1:0]             err_cnt,
    output logic [3:0]                   err_sticky
);
    localparam int CRW = $clog2(CREDITS + 1);
    localparam int BIW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SW  = DATA_W / PAR_W;
    localparam int PKW = DATA_W * BEATS;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t           state_q, state_d;
    logic [BIW-1:0]   idx_q, idx_d;
    logic [PKW-1:0]   buf_q, buf_d;
    logic             acc_q, acc_d;
    logic             pkt_valid_q, pkt_valid_d;
    logic [PKW-1:0]   pkt_data_q, pkt_data_d;
    logic             pkt_par_err_q, pkt_par_err_d;
    logic [CRW-1:0]   credits_q, credits_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [3:0]       sticky_q, sticky_d;

    logic [PAR_W-1:0] exp_par;
    logic             beat_perr;
    logic             cap, accept, last;
    logic [BIW-1:0]   cur_idx;
    logic             e_par, e_busy, e_und, e_ovf, e_tmo;
    logic [2:0]       n_err;
    logic [CNT_W:0]   err_sum;
    logic             full, empty;

    always_comb begin
        for (int i = 0; i < PAR_W; i++) begin
            exp_par[i] = ^bus.sii_ncu_data[i*SW +: SW];
        end
        beat_perr = |(exp_par ^ bus.sii_ncu_dparity);
    end

`ifdef SIU_NCU_MON_TIMEOUT_EN
    localparam int TW = $clog2(GNT_TIMEOUT + 1);
    logic [TW-1:0] wait_q, wait_d;

    // Wait counter only advances while some credit is still out.
    always_comb begin
        wait_d = wait_q;
        e_tmo  = 1'b0;
        if (enable) begin
            if (bus.ncu_sii_gnt) begin
                wait_d = '0;
            end else if (credits_q < CRW'(CREDITS)) begin
                if (wait_q + 1'b1 == TW'(GNT_TIMEOUT)) begin
                    e_tmo  = 1'b1;
                    wait_d = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) wait_q <= '0;
        else        wait_q <= wait_d;
    end
`else
    assign e_tmo = 1'b0;
`endif

    always_comb begin
        full    = (credits_q == CRW'(CREDITS));
        empty   = (credits_q == '0);
        accept  = (state_q == IDLE) && bus.sii_ncu_req;
        cap     = accept || (state_q == BUSY);
        cur_idx = (state_q == IDLE) ? '0 : idx_q;
        last    = (cur_idx == BIW'(BEATS - 1));

        e_par  = cap && beat_perr;
        e_busy = (state_q == BUSY) && bus.sii_ncu_req;
        e_und  = accept && !bus.ncu_sii_gnt && empty;
        e_ovf  = bus.ncu_sii_gnt && !accept && full;

        n_err   = 3'(e_par) + 3'(e_busy) + 3'(e_und)
                + 3'(e_ovf) + 3'(e_tmo);
        err_sum = {1'b0, err_cnt_q} + (CNT_W+1)'(n_err);

        state_d       = state_q;
        idx_d         = idx_q;
        buf_d         = buf_q;
        acc_d         = acc_q;
        pkt_valid_d   = pkt_valid_q;
        pkt_data_d    = pkt_data_q;
        pkt_par_err_d = pkt_par_err_q;
        credits_d     = credits_q;
        pkt_cnt_d     = pkt_cnt_q;
        err_cnt_d     = err_cnt_q;
        sticky_d      = sticky_q;

        if (enable) begin
            pkt_valid_d   = 1'b0;
            pkt_par_err_d = 1'b0;

            if (cap) begin
                buf_d[int'(cur_idx)*DATA_W +: DATA_W] = bus.sii_ncu_data;
                if (last) begin
                    pkt_valid_d   = 1'b1;
                    pkt_data_d    = buf_d;
                    pkt_par_err_d = acc_q | e_par;
                    acc_d         = 1'b0;
                    state_d       = IDLE;
                    idx_d         = '0;
                    if (pkt_cnt_q != '1) pkt_cnt_d = pkt_cnt_q + 1'b1;
                end else begin
                    acc_d   = acc_q | e_par;
                    idx_d   = cur_idx + 1'b1;
                    state_d = BUSY;
                end
            end

            // An accepted req and a gnt in the same cycle cancel out.
            if (accept && !bus.ncu_sii_gnt && !empty) begin
                credits_d = credits_q - 1'b1;
            end else if (bus.ncu_sii_gnt && !accept && !full) begin
                credits_d = credits_q + 1'b1;
            end

            sticky_d = sticky_q | {e_ovf | e_tmo, e_und, e_busy, e_par};
            err_cnt_d = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            buf_q         <= '0;
            acc_q         <= 1'b0;
            pkt_valid_q   <= 1'b0;
            pkt_data_q    <= '0;
            pkt_par_err_q <= 1'b0;
            credits_q     <= CRW'(CREDITS);
            pkt_cnt_q     <= '0;
            err_cnt_q     <= '0;
            sticky_q      <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            buf_q         <= buf_d;
            acc_q         <= acc_d;
            pkt_valid_q   <= pkt_valid_d;
            pkt_data_q    <= pkt_data_d;
            pkt_par_err_q <= pkt_par_err_d;
            credits_q     <= credits_d;
            pkt_cnt_q     <= pkt_cnt_d;
            err_cnt_q     <= err_cnt_d;
            sticky_q      <= sticky_d;
        end
    end

    assign pkt_valid   = pkt_valid_q;
    assign pkt_data    = pkt_data_q;
    assign pkt_par_err = pkt_par_err_q;
    assign credits     = credits_q;
    assign pkt_cnt     = pkt_cnt_q;
    assign err_cnt     = err_cnt_q;
    assign err_sticky  = sticky_q;
endmodule

// File: tb/tb_sii_ncu_pkt_mon.sv
// Bench for sii_ncu_pkt_mon: directed table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_sii_ncu_pkt_mon;
    localparam int DW = 32;
    localparam int PW = 2;
    localparam int NB = 4;
    localparam int CR = 2;
    localparam int CW = 16;
    localparam int MAXC = 65535;

    logic clk = 1'b0;
    logic rst_l = 1'b0;
    logic enable = 1'b0;
    always #5 clk = ~clk;

    sii_ncu_pkt_mon_if #(.DATA_W(DW), .PAR_W(PW)) bus ();

    logic            pkt_valid;
    logic [DW*NB-1:0] pkt_data;
    logic            pkt_par_err;
    logic [1:0]      credits;
    logic [CW-1:0]   pkt_cnt;
    logic [CW-1:0]   err_cnt;
    logic [3:0]      err_sticky;

    sii_ncu_pkt_mon #(
        .DATA_W(DW), .PAR_W(PW), .BEATS(NB),
        .CREDITS(CR), .CNT_W(CW)
    ) dut (
        .iol2clk    (clk),
        .rst_l      (rst_l),
        .enable     (enable),
        .bus        (bus),
        .pkt_valid  (pkt_valid),
        .pkt_data   (pkt_data),
        .pkt_par_err(pkt_par_err),
        .credits    (credits),
        .pkt_cnt    (pkt_cnt),
        .err_cnt    (err_cnt),
        .err_sticky (err_sticky)
    );

    int n_vec = 0;
    int n_bad = 0;
    int strobes = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] good_par(input logic [31:0] d);
        logic [1:0] p;
        p[0] = ^d[15:0];
        p[1] = ^d[31:16];
        return p;
    endfunction

    // Reference model: collected beats live in a queue.
    logic [31:0]  mq[$];
    bit           m_acc;
    int           m_cred, m_pkt, m_err;
    logic [3:0]   m_st;
    logic         m_valid, m_perr;
    logic [127:0] m_data;

    task automatic model_reset();
        mq.delete();
        m_acc = 0; m_cred = CR; m_pkt = 0; m_err = 0;
        m_st = 0; m_valid = 0; m_perr = 0; m_data = 0;
    endtask

    task automatic model_step(input bit en, input bit req,
                              input logic [31:0] d,
                              input logic [1:0] p, input bit g);
        bit busy, accepted;
        int errs;
        if (!en) return;
        busy = (mq.size() != 0);
        accepted = !busy && req;
        errs = 0;
        m_valid = 0;
        m_perr = 0;
        if (busy && req) begin errs++; m_st[1] = 1; end
        if (busy || req) begin
            if (p != good_par(d)) begin
                errs++; m_st[0] = 1; m_acc = 1;
            end
            mq.push_back(d);
        end
        if (accepted && !g) begin
            if (m_cred == 0) begin errs++; m_st[2] = 1; end
            else m_cred--;
        end else if (g && !accepted) begin
            if (m_cred == CR) begin errs++; m_st[3] = 1; end
            else m_cred++;
        end
        if (mq.size() == NB) begin
            for (int i = 0; i < NB; i++) m_data[i*32 +: 32] = mq[i];
            m_valid = 1;
            m_perr = m_acc;
            m_acc = 0;
            mq.delete();
            m_pkt = (m_pkt + 1 > MAXC) ? MAXC : m_pkt + 1;
        end
        m_err = (m_err + errs > MAXC) ? MAXC : m_err + errs;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, pkt_valid, m_valid);
        chk({tag, ".perr"}, pkt_par_err, m_perr);
        chk({tag, ".data"}, pkt_data, m_data);
        chk({tag, ".credits"}, credits, m_cred);
        chk({tag, ".pkt_cnt"}, pkt_cnt, m_pkt);
        chk({tag, ".err_cnt"}, err_cnt, m_err);
        chk({tag, ".sticky"}, err_sticky, m_st);
    endtask

    task automatic cyc(input bit en, input bit req,
                       input logic [31:0] d,
                       input logic [1:0] p, input bit g);
        enable = en;
        bus.sii_ncu_req = req;
        bus.sii_ncu_data = d;
        bus.sii_ncu_dparity = p;
        bus.ncu_sii_gnt = g;
        @(posedge clk);
        #1;
        model_step(en, req, d, p, g);
        if (pkt_valid) strobes++;
        check_all("model");
    endtask

    task automatic pkt(input logic [31:0] d0, input int req_beat);
        logic [31:0] d;
        for (int b = 0; b < NB; b++) begin
            d = d0 + 32'(b);
            cyc(1, b == 0 || b == req_beat, d, good_par(d), 0);
        end
    endtask

    typedef struct {
        bit          req;
        bit          gnt;
        logic [31:0] d;
        logic [1:0]  flip;
        bit          ev;
        bit          ep;
        int          cr;
        logic [3:0]  st;
        int          er;
        int          pk;
    } vec_t;

    vec_t tbl[10];
    int   s0;
    logic [31:0] rd;
    logic [1:0]  rp;

    initial begin
        tbl[0] = '{1, 0, 32'h11111111, 2'b00, 0, 0, 1, 4'h0, 0, 0};
        tbl[1] = '{0, 0, 32'h22222222, 2'b00, 0, 0, 1, 4'h0, 0, 0};
        tbl[2] = '{0, 0, 32'h33333333, 2'b00, 0, 0, 1, 4'h0, 0, 0};
        tbl[3] = '{0, 0, 32'h44444444, 2'b00, 1, 0, 1, 4'h0, 0, 1};
        tbl[4] = '{0, 1, 32'h00000000, 2'b00, 0, 0, 2, 4'h0, 0, 1};
        tbl[5] = '{1, 0, 32'h11111111, 2'b00, 0, 0, 1, 4'h0, 0, 1};
        tbl[6] = '{0, 0, 32'h22222222, 2'b00, 0, 0, 1, 4'h0, 0, 1};
        tbl[7] = '{0, 0, 32'h33333333, 2'b10, 0, 0, 1, 4'h1, 1, 1};
        tbl[8] = '{0, 0, 32'h44444444, 2'b00, 1, 1, 1, 4'h1, 1, 2};
        tbl[9] = '{0, 1, 32'h00000000, 2'b00, 0, 0, 2, 4'h1, 1, 2};

        bus.sii_ncu_req = 0;
        bus.sii_ncu_data = 0;
        bus.sii_ncu_dparity = 0;
        bus.ncu_sii_gnt = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        rst_l = 1'b1;

        for (int i = 0; i < 10; i++) begin
            cyc(1, tbl[i].req, tbl[i].d,
                good_par(tbl[i].d) ^ tbl[i].flip, tbl[i].gnt);
            chk($sformatf("tbl%0d.valid", i), pkt_valid, tbl[i].ev);
            if (tbl[i].ev) chk($sformatf("tbl%0d.perr", i),
                               pkt_par_err, tbl[i].ep);
            chk($sformatf("tbl%0d.cred", i), credits, tbl[i].cr);
            chk($sformatf("tbl%0d.sticky", i), err_sticky, tbl[i].st);
            chk($sformatf("tbl%0d.err", i), err_cnt, tbl[i].er);
            chk($sformatf("tbl%0d.pkt", i), pkt_cnt, tbl[i].pk);
        end
        chk("tbl.pkt_data", pkt_data,
            128'h44444444333333332222222211111111);

        // Three packets with no grants: third req underflows.
        s0 = strobes;
        pkt(32'hA0000000, -1);
        pkt(32'hB0000000, -1);
        pkt(32'hC0000000, -1);
        chk("under.strobes", strobes - s0, 3);
        chk("under.credits", credits, 0);
        chk("under.sticky", err_sticky, 4'b0101);
        chk("under.err", err_cnt, 2);

        // req and gnt together at zero credits: no change, no error.
        cyc(1, 1, 32'h5, good_par(32'h5), 1);
        chk("rg.credits", credits, 0);
        chk("rg.err", err_cnt, 2);
        for (int b = 1; b < NB; b++) cyc(1, 0, 32'h0, 2'b00, 0);
        cyc(1, 0, 32'h0, 2'b00, 1);
        cyc(1, 0, 32'h0, 2'b00, 1);
        chk("gnt.full", credits, 2);
        cyc(1, 0, 32'h0, 2'b00, 1);
        chk("ovf.sticky", err_sticky, 4'b1101);
        chk("ovf.credits", credits, 2);

        // req on beat 1 is flagged but the packet keeps its length.
        s0 = strobes;
        pkt(32'hD0000000, 1);
        chk("busy.strobes", strobes - s0, 1);
        chk("busy.valid", pkt_valid, 1);
        chk("busy.sticky", err_sticky, 4'b1111);
        chk("busy.data", pkt_data,
            128'hD0000003D0000002D0000001D0000000);

        // Reset in the middle of a packet drops it.
        cyc(1, 1, 32'h77, good_par(32'h77), 0);
        cyc(1, 0, 32'h78, good_par(32'h78), 0);
        rst_l = 1'b0;
        #1;
        model_reset();
        check_all("midrst");
        @(posedge clk);
        #1;
        rst_l = 1'b1;
        s0 = strobes;
        for (int i = 0; i < 4; i++) cyc(1, 0, 32'h0, 2'b00, 0);
        chk("midrst.strobes", strobes - s0, 0);

        for (int i = 0; i < 800; i++) begin
            rd = $urandom;
            rp = good_par(rd);
            if ($urandom_range(9) == 0) rp ^= 2'($urandom_range(1, 3));
            cyc($urandom_range(9) != 0, $urandom_range(9) < 3, rd, rp,
                $urandom_range(3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/sii_ncu_pkt_mon.md
Name: sii_ncu_pkt_mon

Overview:
- Parametrised inbound SII->NCU packet monitor/checker that sits passively on the sii_ncu_data/dparity/req and ncu_sii_gnt wires in the iol2clk domain.
- Reassembles multi-beat packets and checks per-lane data parity.
- Tracks the req/gnt credit loop and flags protocol violations.
- Exposes packet strobes, counters and sticky error flags to the bench instead of only printing req.

Parameters:
DATA_W, 32, data bus width per beat
PAR_W, 2, parity bits per beat; each covers DATA_W/PAR_W contiguous bits (bit i covers slice i); DATA_W must divide evenly
BEATS, 4, beats per packet
CREDITS, 2, initial NCU credits (max outstanding ungranted packets)
CNT_W, 16, width of packet and error counters

Ports:
iol2clk  in  1  monitor clock
rst_l  in  1  asynchronous active-low reset
enable  in  1  monitor enable; 0 freezes all state except reset
sii_ncu_req  in  1  first-beat/request strobe
sii_ncu_data  in  DATA_W  beat data
sii_ncu_dparity  in  PAR_W  beat parity
ncu_sii_gnt  in  1  credit-return pulse
pkt_valid  out  1  one-cycle strobe: full packet captured
pkt_data  out  DATA_W*BEATS  packet; beat 0 in LSBs
pkt_par_err  out  1  packet contained at least one parity error (valid with pkt_valid)
credits  out  $clog2(CREDITS+1)  current credit count
pkt_cnt  out  CNT_W  packets completed, saturating
err_cnt  out  CNT_W  total violations, saturating
err_sticky  out  4  [0] parity, [1] req-while-busy, [2] credit underflow, [3] credit overflow/timeout

Behaviour:
- Reset (async assert, sync deassert on iol2clk): FSM IDLE, credits=CREDITS, all other outputs 0.
- All updates occur only when enable=1. Outputs hold when enable=0.
- FSM has two states:
  - IDLE: sii_ncu_req=1 captures beat 0, sets beat_idx=1 and moves to BUSY. If BEATS==1, it completes that same cycle and stays in IDLE.
  - BUSY: every cycle captures beat beat_idx; req is not required. On beat BEATS-1, register pkt_valid=1 and pkt_data the next cycle (latency 1 cycle after the last beat), then return to IDLE.
- Back-to-back packets: a req on the cycle after the last beat is legal (IDLE accepts it).
- Parity is checked every captured beat: expected bit i = XOR of slice i (even parity).
  - On mismatch, set err_sticky[0], increment err_cnt by 1 (per beat, not per lane) and mark the packet pkt_par_err.
- req while BUSY: err_sticky[1], err_cnt++. The beat is still captured as data and the FSM is not restarted.
- Credits:
  - Accepted req (IDLE) decrements credits.
  - req with credits==0 sets err_sticky[2], err_cnt++; the packet is still assembled and credits stay 0.
  - gnt increments credits.
  - gnt with credits==CREDITS sets err_sticky[3], err_cnt++, and credits hold.
  - Simultaneous accepted req and gnt: credits unchanged, no error even if credits==0.
- Multiple violations in one cycle add their count to err_cnt in that single cycle.
- Counters saturate at all-ones.
- Reset mid-packet discards the partial packet with no pkt_valid.

Optional Feature:
SIU_NCU_MON_TIMEOUT_EN
- When defined, adds parameter GNT_TIMEOUT (default 256) and a per-monitor wait counter.
- The counter runs while credits<CREDITS, clears on any gnt, and holds when enable=0.
- When it reaches GNT_TIMEOUT, set err_sticky[3], err_cnt++, and reload the counter to 0 (one error per expiry period).
- When undefined: no counter exists and err_sticky[3] reports overflow only.

Test Plan:
- Reset, enable=1, one req followed by 4 beats 0x11111111..0x44444444 with correct parity, then one gnt -> pkt_valid once, 1 cycle after beat 3; pkt_data=0x44444444333333332222222211111111; credits 2->1->2; pkt_cnt=1; err_cnt=0.
- Beat 2 with dparity[1] flipped -> pkt_par_err=1 with pkt_valid; err_sticky=4'b0001; err_cnt=1.
- Three packets without gnt (CREDITS=2) -> third req sets err_sticky[2]; credits stays 0; all three pkt_valid strobes still occur.
- Req asserted on beat 1 of a packet -> err_sticky[1]; the packet completes normally at the original beat count.
- Req and gnt on the same cycle at credits=0 -> credits 0, no error. A gnt at credits=2 -> err_sticky[3].
- With SIU_NCU_MON_TIMEOUT_EN and GNT_TIMEOUT=8, one packet and no gnt -> err_sticky[3] set 8 cycles after the req; err_cnt increments every further 8 cycles until a gnt arrives.
